// File: rtl/aes_pkg.sv
//==============================================================================
// Module   : aes_pkg
// Brief    : Shared AES-128 constants, GF(2^8) helpers and core state encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EXPAND = 3'd2,
        ST_DEC    = 3'd3,
        ST_OUT    = 3'd4
    } aes_state_e;

    localparam logic [7:0] C_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] C_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] C_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round numbers outside 1..10 carry no constant.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) begin
            return C_RCON[r];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column layout: col[31:24] is row 0.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
//==============================================================================
// Module   : aes_inv_round
// Brief    : Combinational AES inverse round; i_last skips InvMixColumns.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int SRC = ((((gi / 4) - ROW) + 4) % 4) * 4 + ROW;
        assign w_ark[127-8*gi -: 8] = C_INV_SBOX[i_state[127-8*SRC -: 8]]
                                      ^ i_round_key[127-8*gi -: 8];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        assign w_mix[127-32*gc -: 32] = inv_mix_column(w_ark[127-32*gc -: 32]);
    end

    assign o_state = i_last ? w_ark : w_mix;

endmodule

`default_nettype wire

// File: rtl/aes_decryption.sv
//==============================================================================
// Module   : aes_decryption
// Brief    : Byte-serial AES-128 decryption core with load/ready handshake.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_decryption
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] key_byte,
    input  logic [7:0] state_byte,
    output logic [7:0] state_out_byte,
    output logic       load,
    output logic       ready
);

    aes_state_e   r_state;
    logic [4:0]   r_cnt;
    logic [127:0] r_key;
    logic [127:0] r_ct;
    logic         r_load;
    logic         r_ready;
    logic [7:0]   r_out_byte;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_b3;
    logic [31:0]  w_rot_in, w_rot, w_sub_word, w_temp;
    logic [127:0] w_key_fwd;
    logic [127:0] w_key_back;
    logic [127:0] w_round_out;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_b3 = w_w3 ^ w_w2;

    // One SubWord serves both directions: forward uses w3, roll-back uses the new w3.
    assign w_rot_in = (r_state == ST_EXPAND) ? w_w3 : w_b3;
    assign w_rot    = {w_rot_in[23:0], w_rot_in[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        assign w_sub_word[8*gi +: 8] = C_SBOX[w_rot[8*gi +: 8]];
    end

    assign w_temp = w_sub_word ^ {rcon(r_cnt[3:0]), 24'h000000};

    always_comb begin
        logic [31:0] v0, v1, v2;
        v0 = w_w0 ^ w_temp;
        v1 = w_w1 ^ v0;
        v2 = w_w2 ^ v1;
        w_key_fwd  = {v0, v1, v2, w_w3 ^ v2};
        w_key_back = {w_w0 ^ w_temp, w_w1 ^ w_w0, w_w2 ^ w_w1, w_b3};
    end

    aes_inv_round u_inv_round (
        .i_state     (r_ct),
        .i_round_key (r_key),
        .i_last      (r_cnt == 5'd0),
        .o_state     (w_round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_key      <= '0;
            r_ct       <= '0;
            r_load     <= 1'b0;
            r_ready    <= 1'b0;
            r_out_byte <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= 5'd0;
                        r_load  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (enable) begin
                        r_key <= {r_key[119:0], key_byte};
                        r_ct  <= {r_ct[119:0], state_byte};
                        if (r_cnt == 5'd15) begin
                            r_state <= ST_EXPAND;
                            r_cnt   <= 5'd1;
                            r_load  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                ST_EXPAND: begin
                    r_key <= w_key_fwd;
                    if (r_cnt == 5'd10) begin
                        r_state <= ST_DEC;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_DEC: begin
                    r_ct <= (r_cnt == 5'd10) ? (r_ct ^ r_key) : w_round_out;
                    if (r_cnt == 5'd0) begin
                        r_state <= ST_OUT;
                    end else begin
                        r_key <= w_key_back;
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_OUT: begin
                    // Output register trails the state by one edge; count 16 closes the block.
                    if (r_cnt == 5'd16) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= 5'd0;
                        r_ready    <= 1'b0;
                        r_out_byte <= 8'h00;
                    end else begin
                        r_ready    <= 1'b1;
                        r_out_byte <= r_ct[{~r_cnt[3:0], 3'b000} +: 8];
                        r_cnt      <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_out_byte = r_out_byte;
    assign load           = r_load;
    assign ready          = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_aes_decryption.sv
//==============================================================================
// Module   : tb_aes_decryption
// Brief    : Self-checking bench for aes_decryption against an AES reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aes_decryption;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] key_byte = 8'h00;
    logic [7:0] state_byte = 8'h00;
    logic [7:0] state_out_byte;
    logic       load;
    logic       ready;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         chk_on = 1'b0;
    logic       exp_load = 1'b0;
    logic       exp_ready = 1'b0;
    logic [7:0] exp_byte = 8'h00;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    localparam logic [127:0] C_KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY2  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] C_CT2   = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] C_PT2   = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] C_K10_2 = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;

    aes_decryption dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .key_byte       (key_byte),
        .state_byte     (state_byte),
        .state_out_byte (state_out_byte),
        .load           (load),
        .ready          (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("load", {127'd0, load}, {127'd0, exp_load});
            check("ready", {127'd0, ready}, {127'd0, exp_ready});
            check("state_out_byte", {120'd0, state_out_byte}, {120'd0, exp_byte});
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] bt(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [7:0] rc(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < r; i++) v = gmul(v, 8'h02);
        return v;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {sb[w3[23:16]] ^ rc(r), sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [127:0] r;
        r = k;
        for (int i = 1; i <= n; i++) r = next_key(r, i);
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isb[bt(s, i)] : sb[bt(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = bt(s, 4*src + r);
            end
        end
        return o;
    endfunction

    // Circulant column mix; coefs holds the first matrix row.
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coefs);
        logic [127:0] o;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coefs[31-8*((j-i+4)%4) -: 8], bt(s, 4*c+j));
                o[127-8*(4*c+i) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] st, k;
        k  = key;
        st = pt ^ k;
        for (int r = 1; r <= 10; r++) begin
            k  = next_key(k, r);
            st = shift_rows(sub_bytes(st, 1'b0), 1'b0);
            if (r < 10) st = mix(st, 32'h02030101);
            st = st ^ k;
        end
        return st;
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [127:0] rk [11];
        logic [127:0] st;
        rk[0] = key;
        for (int r = 1; r <= 10; r++) rk[r] = next_key(rk[r-1], r);
        st = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            st = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk[r];
            if (r > 0) st = mix(st, 32'h0e0b0d09);
        end
        return st;
    endfunction

    // ---------------- stimulus ----------------
    task automatic edge_step(input logic l, input logic r, input logic [7:0] b);
        @(posedge clk);
        #1;
        exp_load  = l;
        exp_ready = r;
        exp_byte  = b;
    endtask

    // abort_at counts edges after the last capture (1 = first EXPAND edge).
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                             input logic [127:0] pt_ref, input logic [15:0] stall_mask,
                             input bit b2b, input bit wild_en, input int abort_at, input bit chk_k10);
        logic [127:0] pt_model, got;
        int k;
        pt_model = model_decrypt(key, ct);
        got      = '0;
        enable   = 1'b1;
        edge_step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            if (stall_mask[i]) begin
                enable     = 1'b0;
                key_byte   = 8'($urandom);
                state_byte = 8'($urandom);
                edge_step(1'b1, 1'b0, 8'h00);
            end
            enable     = 1'b1;
            key_byte   = key[127-8*i -: 8];
            state_byte = ct[127-8*i -: 8];
            edge_step(i != 15, 1'b0, 8'h00);
        end
        for (int p = 1; p <= 38; p++) begin
            enable = wild_en ? 1'($urandom_range(0, 1)) : b2b;
            if (p == abort_at) begin
                rst = 1'b1;
                edge_step(1'b0, 1'b0, 8'h00);
                rst    = 1'b0;
                enable = 1'b0;
                return;
            end
            if (p >= 22 && p <= 37) begin
                k = p - 22;
                edge_step(1'b0, 1'b1, pt_model[127-8*k -: 8]);
                got[127-8*k -: 8] = state_out_byte;
            end else begin
                edge_step(1'b0, 1'b0, 8'h00);
            end
            if (p == 10 && chk_k10) check({tag, "_k10"}, dut.r_key, C_K10_2);
        end
        enable = b2b;
        check({tag, "_model_pt"}, pt_model, pt_ref);
        check({tag, "_plaintext"}, got, pt_ref);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]   inv, s;
        logic [15:0]  mask;
        logic [127:0] rk, rp, rct;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end

        check("model_enc_v1", model_encrypt(C_KEY1, C_PT1), C_CT1);
        check("model_enc_v2", model_encrypt(C_KEY2, C_PT2), C_CT2);
        check("model_k10_v2", round_key(C_KEY2, 10), C_K10_2);

        @(posedge clk);
        #1;
        chk_on = 1'b1;
        edge_step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        edge_step(1'b0, 1'b0, 8'h00);

        run_block("v1", C_KEY1, C_CT1, C_PT1, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        edge_step(1'b0, 1'b0, 8'h00);
        run_block("v2", C_KEY2, C_CT2, C_PT2, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        edge_step(1'b0, 1'b0, 8'h00);

        mask = 16'h0000;
        while ($countones(mask) < 3) mask[$urandom_range(0, 15)] = 1'b1;
        run_block("stall", C_KEY1, C_CT1, C_PT1, mask, 1'b0, 1'b0, 0, 1'b0);
        edge_step(1'b0, 1'b0, 8'h00);

        run_block("rst_dec", C_KEY2, C_CT2, C_PT2, 16'h0000, 1'b0, 1'b0, 16, 1'b0);
        edge_step(1'b0, 1'b0, 8'h00);
        run_block("after_rst_dec", C_KEY1, C_CT1, C_PT1, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        run_block("rst_out", C_KEY1, C_CT1, C_PT1, 16'h0000, 1'b0, 1'b0, 30, 1'b0);
        run_block("after_rst_out", C_KEY2, C_CT2, C_PT2, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        edge_step(1'b0, 1'b0, 8'h00);

        run_block("b2b_a", C_KEY1, C_CT1, C_PT1, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        run_block("b2b_b", C_KEY2, C_CT2, C_PT2, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
        run_block("b2b_c", C_KEY1, C_CT1, C_PT1, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        enable = 1'b0;
        edge_step(1'b0, 1'b0, 8'h00);

        for (int n = 0; n < 16; n++) begin
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rp  = {$urandom, $urandom, $urandom, $urandom};
            rct = model_encrypt(rk, rp);
            run_block("roundtrip", rk, rct, rp, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
            edge_step(1'b0, 1'b0, 8'h00);
        end

        edge_step(1'b0, 1'b0, 8'h00);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
